// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-master (instruction fetch m0, LSU m1) arbiter onto a single
//            memory port with one outstanding transaction, m1 priority with
//            bounded starvation of m0, and a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_t;

    state_t        state;
    logic          owner;        // 0 = m0 owns the outstanding transaction
    logic [SW-1:0] starve_cnt;   // consecutive m1 grants while m0 waits
    logic [TW-1:0] tmo_cnt;      // cycles spent in WAIT_RESP

    logic in_wait;
    logic resp;
    logic abort;
    logic arb_en;
    logic sel_m1;
    logic grant;
    logic rsp_fire;

    // Arbitration, memory-port muxing and response routing (all zero-latency)
    always_comb begin
        in_wait  = (state == WAIT_RESP);
        resp     = in_wait && mem_rvalid_i;
        abort    = in_wait && !mem_rvalid_i && (tmo_cnt == TMO_LAST);
        // A new grant may issue from IDLE or in the cycle the response lands
        arb_en   = !rst_i && (!in_wait || mem_rvalid_i);
        sel_m1   = m1_req_i && !(m0_req_i && (starve_cnt == STARVE_MAX));
        grant    = arb_en && (m0_req_i || m1_req_i);
        rsp_fire = !rst_i && (resp || abort);

        m0_gnt_o    = grant && !sel_m1;
        m1_gnt_o    = grant && sel_m1;

        mem_req_o   = grant;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (grant) begin
            mem_we_o    = sel_m1 ? m1_we_i    : m0_we_i;
            mem_be_o    = sel_m1 ? m1_be_i    : m0_be_i;
            mem_addr_o  = sel_m1 ? m1_addr_i  : m0_addr_i;
            mem_wdata_o = sel_m1 ? m1_wdata_i : m0_wdata_i;
        end

        // Abort responses carry zero data; only a real response forwards rdata
        m0_rvalid_o = rsp_fire && !owner;
        m1_rvalid_o = rsp_fire && owner;
        m0_err_o    = !rst_i && abort && !owner;
        m1_err_o    = !rst_i && abort && owner;
        m0_rdata_o  = (m0_rvalid_o && resp) ? mem_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o && resp) ? mem_rdata_i : 32'h0;
    end

    // FSM, owner, timeout counter and starvation counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (grant) begin
                state   <= WAIT_RESP;
                owner   <= sel_m1;
                tmo_cnt <= '0;
            end else if (resp || abort) begin
                state   <= IDLE;
            end else if (in_wait) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (!m0_req_i || m0_gnt_o) begin
                starve_cnt <= '0;
            end else if (m1_gnt_o && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed scenarios followed
//            by randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model: is a transaction outstanding, who owns it,
    // was it a write, how long it has waited, and how often m0 was passed over
    bit m_busy, m_owner, m_we;
    int m_age, m_starve;
    int mem_lat;   // remaining cycles before the memory model answers

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk_resp(input string nm, input bit k, input logic rv,
                            input logic [31:0] rd, input logic er,
                            input bit rsp, input bit abt);
        bit own;
        own = m_busy && (m_owner == k);
        check({nm, "_rvalid"}, rv, own && (rsp || abt));
        check({nm, "_err"}, er, own && abt);
        if (own && abt)               check({nm, "_rdata_abort"}, rd, 32'h0);
        else if (own && rsp && !m_we) check({nm, "_rdata"}, rd, mem_rdata_i);
        else if (m_busy && !own)      check({nm, "_rdata_nonowner"}, rd, 32'h0);
    endtask

    // Check the current cycle against the model, advance the model, go to next negedge
    task automatic tick();
        bit rsp, abt, g0, g1;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (rst_i) begin
            check("rst_m0_gnt", m0_gnt_o, 0);    check("rst_m1_gnt", m1_gnt_o, 0);
            check("rst_m0_rvalid", m0_rvalid_o, 0); check("rst_m1_rvalid", m1_rvalid_o, 0);
            check("rst_m0_err", m0_err_o, 0);    check("rst_m1_err", m1_err_o, 0);
            check("rst_m0_rdata", m0_rdata_o, 0); check("rst_m1_rdata", m1_rdata_o, 0);
            check("rst_mem_req", mem_req_o, 0);
            m_busy = 0; m_owner = 0; m_age = 0; m_starve = 0;
        end else begin
            rsp = m_busy && mem_rvalid_i;
            abt = m_busy && !mem_rvalid_i && (m_age == TIMEOUT - 1);
            if ((!m_busy || rsp) && (m0_req_i || m1_req_i)) begin
                if (m0_req_i && m1_req_i) g1 = (m_starve < STARVE_LIMIT);
                else                      g1 = m1_req_i;
                g0 = !g1;
            end
            check("m0_gnt", m0_gnt_o, g0);
            check("m1_gnt", m1_gnt_o, g1);
            check("mem_req", mem_req_o, g0 | g1);
            check("mem_we", mem_we_o, g1 ? m1_we_i : (g0 ? m0_we_i : 1'b0));
            check("mem_be", mem_be_o, g1 ? m1_be_i : (g0 ? m0_be_i : 4'h0));
            check("mem_addr", mem_addr_o, g1 ? m1_addr_i : (g0 ? m0_addr_i : 32'h0));
            check("mem_wdata", mem_wdata_o, g1 ? m1_wdata_i : (g0 ? m0_wdata_i : 32'h0));
            chk_resp("m0", 1'b0, m0_rvalid_o, m0_rdata_o, m0_err_o, rsp, abt);
            chk_resp("m1", 1'b1, m1_rvalid_o, m1_rdata_o, m1_err_o, rsp, abt);

            if (!m0_req_i || g0)               m_starve = 0;
            else if (g1 && m_starve < STARVE_LIMIT) m_starve++;
            if (g0 || g1) begin
                m_busy = 1; m_owner = g1; m_age = 0;
                m_we = g1 ? m1_we_i : m0_we_i;
                mem_lat = ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, 3);
            end else if (rsp || abt) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_age++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        rst_i = 0; m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
        m0_be_i = 4'hF; m1_be_i = 4'hF; m0_addr_i = 0; m1_addr_i = 0;
        m0_wdata_i = 0; m1_wdata_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    initial begin
        int waits;
        bit seen;
        idle_inputs();
        mem_lat = 0;

        // Reset with requests and a memory response present
        rst_i = 1; m0_req_i = 1; m1_req_i = 1; mem_rvalid_i = 1;
        tick(); tick();
        idle_inputs();
        tick();

        // Single read by m0, answered two cycles after the grant
        m0_req_i = 1; m0_addr_i = 32'h100;
        #1;
        check("rd_m0_gnt", m0_gnt_o, 1);
        check("rd_mem_addr", mem_addr_o, 32'h100);
        tick();
        m0_req_i = 0;
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0001;
        #1;
        check("rd_m0_rvalid", m0_rvalid_o, 1);
        check("rd_m0_rdata", m0_rdata_o, 32'hCAFE0001);
        check("rd_m1_rvalid", m1_rvalid_o, 0);
        tick();
        idle_inputs();
        tick();

        // Contention with one-cycle memory latency: m1 x4 then m0, repeating
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'hA0; m1_addr_i = 32'hB0;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid_i = m_busy;
            mem_rdata_i  = 32'h5000 + i;
            #1;
            check("cont_m1_gnt", m1_gnt_o, (i % 5 == 4) ? 0 : 1);
            tick();
        end
        m0_req_i = 0; m1_req_i = 0; mem_rvalid_i = 1;
        tick();
        idle_inputs();
        tick();

        // Back-to-back: m1 write acknowledged in the same cycle m0 is granted
        m0_req_i = 1; m1_req_i = 1; m1_we_i = 1; m1_be_i = 4'b0011; m1_wdata_i = 32'h1234;
        #1;
        check("b2b_m1_gnt", m1_gnt_o, 1);
        check("b2b_mem_be", mem_be_o, 4'b0011);
        tick();
        m1_req_i = 0; mem_rvalid_i = 1;
        #1;
        check("b2b_m1_rvalid", m1_rvalid_o, 1);
        check("b2b_m0_gnt", m0_gnt_o, 1);
        check("b2b_mem_req", mem_req_o, 1);
        tick();
        m0_req_i = 0;
        tick();
        idle_inputs();
        tick();

        // Timeout: m1 read with the memory silent
        m1_req_i = 1; m1_addr_i = 32'h200;
        tick();
        m1_req_i = 0;
        waits = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            waits++;
            #1;
            if (m1_err_o) begin
                seen = 1;
                check("tmo_m1_rvalid", m1_rvalid_o, 1);
                check("tmo_m1_rdata", m1_rdata_o, 32'h0);
            end
            tick();
        end
        check("tmo_wait_cycles", waits, TIMEOUT);
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD;
        #1;
        check("late_m1_rvalid", m1_rvalid_o, 0);
        check("late_m0_rvalid", m0_rvalid_o, 0);
        tick();
        idle_inputs();

        // Reset in the middle of an m0 transaction
        m0_req_i = 1;
        tick();
        m0_req_i = 0; rst_i = 1; m1_req_i = 1; mem_rvalid_i = 1;
        #1;
        check("rstmid_m0_rvalid", m0_rvalid_o, 0);
        check("rstmid_mem_req", mem_req_o, 0);
        tick();
        rst_i = 0; mem_rvalid_i = 0; m0_req_i = 1; m1_req_i = 1;
        #1;
        check("rstmid_m1_gnt", m1_gnt_o, 1);
        tick();
        idle_inputs();
        mem_rvalid_i = 1;
        tick();

        // Randomized traffic
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            rst_i      = ($urandom_range(0, 199) == 0);
            m0_req_i   = ($urandom_range(0, 99) < 60);
            m1_req_i   = ($urandom_range(0, 99) < 60);
            m0_we_i    = $urandom_range(0, 1);
            m1_we_i    = $urandom_range(0, 1);
            m0_be_i    = 4'($urandom);
            m1_be_i    = 4'($urandom);
            m0_addr_i  = $urandom;
            m1_addr_i  = $urandom;
            m0_wdata_i = $urandom;
            m1_wdata_i = $urandom;
            mem_rdata_i = $urandom;
            if (m_busy) begin
                mem_rvalid_i = (mem_lat == 0);
                mem_lat--;
            end else begin
                mem_rvalid_i = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive m1 grants allowed while m0 is pending.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of WAIT_RESP cycles before abort.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports m0_req_i/m1_req_i  input  1  request from instruction-fetch (m0) / LSU data port (m1).
REQ-006 SHALL have ports mX_we_i  input  1, mX_be_i  input  4, mX_addr_i  input  32, mX_wdata_i  input  32  request attributes, valid while mX_req_i=1.
REQ-007 SHALL have ports mX_gnt_o  output  1  request accepted this cycle.
REQ-008 SHALL have ports mX_rvalid_o  output  1, mX_rdata_o  output  32, mX_err_o  output  1  response to master X.
REQ-009 SHALL have ports mem_req_o  output  1, mem_we_o  output  1, mem_be_o  output  4, mem_addr_o  output  32, mem_wdata_o  output  32  single shared memory port.
REQ-010 SHALL have ports mem_rvalid_i  input  1, mem_rdata_i  input  32  memory response; one response per accepted request.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT_RESP, with at most one outstanding memory transaction.
REQ-012 In IDLE with any mX_req_i=1, the block SHALL combinationally assert mem_req_o, drive mem_* from the winner's inputs, assert the winner's mX_gnt_o, and go to WAIT_RESP next cycle.
REQ-013 SHALL register the owner (0/1) at grant.
REQ-014 Arbitration: m1 SHALL win when both request, unless starve_cnt = STARVE_LIMIT, in which case m0 SHALL win.
REQ-015 starve_cnt SHALL increment on each m1 grant while m0_req_i=1, SHALL clear on any m0 grant or whenever m0_req_i=0, and SHALL saturate at STARVE_LIMIT.
REQ-016 The loser's gnt SHALL be 0; a master's gnt SHALL never be asserted without its req.
REQ-017 With no request, mem_req_o SHALL be 0 and mem_we_o/mem_be_o SHALL be 0; mem_addr_o/mem_wdata_o SHALL be don't-care but stable (0).
REQ-018 In WAIT_RESP, mem_rvalid_i=1 SHALL combinationally produce owner mX_rvalid_o=1 and mX_rdata_o=mem_rdata_i.
REQ-019 The non-owner's rvalid SHALL stay 0 and its rdata SHALL be 0.
REQ-020 Writes SHALL also complete with rvalid, which the master uses as acknowledge; rdata on a write is don't-care.
REQ-021 Back-to-back: in WAIT_RESP, the same cycle mem_rvalid_i=1 SHALL perform IDLE arbitration per REQ-012/014, and SHALL remain in WAIT_RESP if a grant is issued, else return to IDLE.
REQ-022 In WAIT_RESP without mem_rvalid_i, mem_req_o SHALL be 0 and all gnt SHALL be 0.
REQ-023 A timeout counter SHALL clear on grant and increment each WAIT_RESP cycle.
REQ-024 When the counter reaches TIMEOUT-1 without mem_rvalid_i, the block SHALL pulse owner mX_rvalid_o=1, mX_err_o=1, mX_rdata_o=32'h0 for one cycle and return to IDLE without granting that cycle.
REQ-025 A late mem_rvalid_i received in IDLE SHALL be ignored.
REQ-026 mX_err_o SHALL be 0 at all other times.
REQ-027 mem_rvalid_i asserted in IDLE SHALL produce no master response.
REQ-028 Grant latency SHALL be 0 cycles (same cycle as req in IDLE).
REQ-029 Response forwarding latency SHALL be 0 cycles.

Reset
REQ-030 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, owner=0, starve_cnt=0, and timeout counter=0.
REQ-031 During rst_i=1, all gnt, rvalid, err and mem_req_o outputs SHALL be 0 and rdata outputs SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no response to the owner; a subsequent stray mem_rvalid_i SHALL be ignored per REQ-027.

Verification
REQ-033 Single read: m0_req=1, addr=0x100 in IDLE -> m0_gnt=1, mem_req=1, mem_addr=0x100 same cycle; memory returns 0xCAFE0001 two cycles later -> m0_rvalid=1, m0_rdata=0xCAFE0001, m1_rvalid=0.
REQ-034 Contention: m0 and m1 requesting continuously, memory latency 1 -> grants m1,m1,m1,m1,m0,m1,... (STARVE_LIMIT=4); each response is routed to the correct master.
REQ-035 Back-to-back: m1 write (be=4'b0011, wdata=0x1234) with m0 pending; rvalid arrives -> m1_rvalid=1 and m0_gnt=1 in the same cycle, with no idle cycle on mem_req_o.
REQ-036 Timeout: m1 read with memory silent -> on the 16th WAIT_RESP cycle m1_rvalid=1, m1_err=1, m1_rdata=0; next cycle IDLE; injected late mem_rvalid produces no response.
REQ-037 Reset mid-op: grant m0, assert rst_i in WAIT_RESP -> all outputs 0; after release a fresh m1 request is granted immediately and starve_cnt starts from 0.
